// File: rtl/fifo_write_scheduler_pkg.sv
// Shared definitions for the FIFO write scheduler: default widths and FSM state encoding.
package ccd_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_write_scheduler_if.sv
// Producer-side control and FIFO write bus of the write scheduler.
interface fifo_write_scheduler_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LEN_W   = 9,
    parameter int unsigned STALL_W = 16
);
    logic               start;
    logic [LEN_W-1:0]   burst_len;
    logic [DATA_W-1:0]  seed;
    logic               abort;
    logic               full;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [LEN_W-1:0]   words_written;
    logic [STALL_W-1:0] stall_cycles;

    modport master (
        input  start, burst_len, seed, abort, full,
        output wr_en, wr_data, busy, done, aborted, words_written, stall_cycles
    );

    modport slave (
        output start, burst_len, seed, abort, full,
        input  wr_en, wr_data, busy, done, aborted, words_written, stall_cycles
    );
endinterface

// File: rtl/fifo_write_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear (priority over enable) and async reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/fifo_write_scheduler.sv
// Issues a burst of incrementing data words into an async FIFO write port,
// stalling on full and terminating early on abort.
module fifo_write_scheduler
    import ccd_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned STALL_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    fifo_write_scheduler_if.master bus
);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              wr_en;
    logic              accept;
    logic              stall_en;

    // abort wins over both full and the final write of the burst
    assign wr_en    = (state_q == WRITE) && !bus.full && !bus.abort;
    assign stall_en = (state_q == WRITE) && bus.full && !bus.abort;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wr_data_d   = wr_data_q;
        words_d     = words_q;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && (bus.burst_len != '0)) begin
                    accept      = 1'b1;
                    state_d     = WRITE;
                    remaining_d = bus.burst_len;
                    wr_data_d   = bus.seed;
                    words_d     = '0;
                end
            end
            WRITE: begin
                if (bus.abort) begin
                    state_d = ABORT;
                end else if (wr_en) begin
                    wr_data_d   = wr_data_q + DATA_ONE;
                    remaining_d = remaining_q - LEN_ONE;
                    words_d     = words_q + LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            wr_data_q   <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wr_data_q   <= wr_data_d;
            words_q     <= words_d;
        end
    end

    sat_counter #(
        .WIDTH(STALL_W)
    ) u_stall_cnt (
        .clk    (CLK),
        .rst    (RST),
        .clr_i  (accept),
        .en_i   (stall_en),
        .count_o(bus.stall_cycles)
    );

    assign bus.wr_en         = wr_en;
    assign bus.wr_data       = wr_data_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.aborted       = (state_q == ABORT);
    assign bus.words_written = words_q;
endmodule

// File: tb/tb_fifo_write_scheduler.sv
// Directed bench for fifo_write_scheduler: inputs change on the falling edge, outputs checked 1 ns later.
module tb_fifo_write_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fifo_write_scheduler_if #(.DATA_W(8), .LEN_W(9), .STALL_W(16)) bus_if ();

    fifo_write_scheduler #(.DATA_W(8), .LEN_W(9), .STALL_W(16)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic start_burst(input logic [8:0] len, input logic [7:0] sd);
        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.burst_len = len;
        bus_if.seed      = sd;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus_if.wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", bus_if.wr_en); end
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.wr_data !== 8'h00) begin failures++; $display("FAIL rst_wr_data got=%h exp=00", bus_if.wr_data); end
        checks++; if (bus_if.words_written !== 9'd0) begin failures++; $display("FAIL rst_words got=%0d exp=0", bus_if.words_written); end
        checks++; if (bus_if.stall_cycles !== 16'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", bus_if.stall_cycles); end
        checks++; if ({bus_if.done, bus_if.aborted} !== 2'b00) begin failures++; $display("FAIL rst_pulses got=%b exp=00", {bus_if.done, bus_if.aborted}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        start_burst(9'd4, 8'h10);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus_if.wr_en !== 1'b1) begin failures++; $display("FAIL basic_wr_en[%0d] got=%b exp=1", i, bus_if.wr_en); end
            checks++; if (bus_if.wr_data !== 8'(8'h10 + i)) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, bus_if.wr_data, 8'(8'h10 + i)); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus_if.done !== 1'b1 || bus_if.wr_en !== 1'b0) begin failures++; $display("FAIL basic_done got=%b/%b exp=1/0", bus_if.done, bus_if.wr_en); end
        checks++; if (bus_if.words_written !== 9'd4) begin failures++; $display("FAIL basic_words got=%0d exp=4", bus_if.words_written); end
        checks++; if (bus_if.stall_cycles !== 16'd0) begin failures++; $display("FAIL basic_stall got=%0d exp=0", bus_if.stall_cycles); end
        @(negedge clk); #1;
        checks++; if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b/%b exp=0/0", bus_if.done, bus_if.busy); end
        @(negedge clk); #1;
        checks++; if (bus_if.words_written !== 9'd4) begin failures++; $display("FAIL basic_words_hold got=%0d exp=4", bus_if.words_written); end
    endtask

    task automatic test_full;
        logic       full_v [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       en_v   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] data_v [5] = '{8'h20, 8'h21, 8'h21, 8'h21, 8'h22};
        start_burst(9'd3, 8'h20);
        for (int i = 0; i < 5; i++) begin
            bus_if.full = full_v[i];
            #1;
            checks++; if (bus_if.wr_en !== en_v[i]) begin failures++; $display("FAIL full_wr_en[%0d] got=%b exp=%b", i, bus_if.wr_en, en_v[i]); end
            checks++; if (bus_if.wr_data !== data_v[i]) begin failures++; $display("FAIL full_data[%0d] got=%h exp=%h", i, bus_if.wr_data, data_v[i]); end
            @(negedge clk);
        end
        bus_if.full = 1'b0;
        #1;
        checks++; if (bus_if.done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", bus_if.done); end
        checks++; if (bus_if.stall_cycles !== 16'd2) begin failures++; $display("FAIL full_stall got=%0d exp=2", bus_if.stall_cycles); end
        checks++; if (bus_if.words_written !== 9'd3) begin failures++; $display("FAIL full_words got=%0d exp=3", bus_if.words_written); end
        @(negedge clk); #1;
        checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL full_done_once got=%b exp=0", bus_if.done); end
    endtask

    task automatic test_wrap;
        logic [7:0] data_v [3] = '{8'hFE, 8'hFF, 8'h00};
        start_burst(9'd3, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            // a start mid-burst must not reload the burst
            bus_if.start     = (i == 1);
            bus_if.seed      = 8'h55;
            bus_if.burst_len = 9'd1;
            #1;
            checks++; if (bus_if.wr_en !== 1'b1 || bus_if.wr_data !== data_v[i]) begin failures++; $display("FAIL wrap_data[%0d] got=%b/%h exp=1/%h", i, bus_if.wr_en, bus_if.wr_data, data_v[i]); end
            @(negedge clk);
        end
        bus_if.start = 1'b0;
        #1;
        checks++; if (bus_if.done !== 1'b1 || bus_if.words_written !== 9'd3) begin failures++; $display("FAIL wrap_done got=%b/%0d exp=1/3", bus_if.done, bus_if.words_written); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        start_burst(9'd10, 8'h30);
        @(negedge clk);
        @(negedge clk);
        bus_if.abort = 1'b1;
        bus_if.full  = 1'b1;
        #1;
        checks++; if (bus_if.wr_en !== 1'b0) begin failures++; $display("FAIL abort_no_write got=%b exp=0", bus_if.wr_en); end
        @(negedge clk);
        bus_if.abort = 1'b0;
        bus_if.full  = 1'b0;
        #1;
        checks++; if (bus_if.aborted !== 1'b1 || bus_if.done !== 1'b0) begin failures++; $display("FAIL abort_pulse got=%b/%b exp=1/0", bus_if.aborted, bus_if.done); end
        checks++; if (bus_if.words_written !== 9'd2) begin failures++; $display("FAIL abort_words got=%0d exp=2", bus_if.words_written); end
        checks++; if (bus_if.stall_cycles !== 16'd0) begin failures++; $display("FAIL abort_stall got=%0d exp=0", bus_if.stall_cycles); end
        @(negedge clk); #1;
        checks++; if (bus_if.busy !== 1'b0 || bus_if.aborted !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b/%b exp=0/0", bus_if.busy, bus_if.aborted); end
        bus_if.abort = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus_if.busy !== 1'b0 || bus_if.aborted !== 1'b0) begin failures++; $display("FAIL abort_in_idle got=%b/%b exp=0/0", bus_if.busy, bus_if.aborted); end
        bus_if.abort = 1'b0;
    endtask

    task automatic test_rst_mid_burst;
        start_burst(9'd8, 8'h40);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus_if.wr_en !== 1'b0 || bus_if.busy !== 1'b0) begin failures++; $display("FAIL rstmid_drop got=%b/%b exp=0/0", bus_if.wr_en, bus_if.busy); end
        checks++; if ({bus_if.wr_data, bus_if.words_written, bus_if.stall_cycles, bus_if.done, bus_if.aborted} !== '0) begin failures++; $display("FAIL rstmid_zero data=%h words=%0d stall=%0d exp=0", bus_if.wr_data, bus_if.words_written, bus_if.stall_cycles); end
        @(negedge clk);
        rst = 1'b0;
        start_burst(9'd0, 8'h77);
        #1;
        checks++; if (bus_if.busy !== 1'b0 || bus_if.wr_en !== 1'b0 || bus_if.done !== 1'b0) begin failures++; $display("FAIL len0_ignored got=%b/%b/%b exp=0/0/0", bus_if.busy, bus_if.wr_en, bus_if.done); end
    endtask

    task automatic test_long;
        int         writes = 0;
        int         dones = 0;
        logic [7:0] last = 8'h00;
        logic [7:0] at_done = 8'h00;
        bit         finished = 1'b0;
        start_burst(9'd511, 8'hFF);
        for (int c = 0; c < 600; c++) begin
            #1;
            if (bus_if.wr_en) begin writes++; last = bus_if.wr_data; end
            if (bus_if.done) begin dones++; at_done = bus_if.wr_data; end
            if (!bus_if.busy) begin finished = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!finished) begin failures++; $display("FAIL long_timeout got=busy exp=idle within 600 cycles"); end
        checks++; if (writes != 511) begin failures++; $display("FAIL long_writes got=%0d exp=511", writes); end
        // last written word is 0xFF+510; the register then advances once more to 0xFE
        checks++; if (last !== 8'hFD) begin failures++; $display("FAIL long_last_word got=%h exp=fd", last); end
        checks++; if (at_done !== 8'hFE) begin failures++; $display("FAIL long_data_at_done got=%h exp=fe", at_done); end
        checks++; if (dones != 1) begin failures++; $display("FAIL long_done_count got=%0d exp=1", dones); end
        checks++; if (bus_if.words_written !== 9'd511) begin failures++; $display("FAIL long_words got=%0d exp=511", bus_if.words_written); end
    endtask

    initial begin
        bus_if.start     = 1'b0;
        bus_if.burst_len = '0;
        bus_if.seed      = '0;
        bus_if.abort     = 1'b0;
        bus_if.full      = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_abort();
        test_rst_mid_burst();
        test_long();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
